// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: operand forwarding and hazard detection for the in-order pipeline.
// The youngest matching bypass source feeds each read port. A registered busy bit per
// architectural register records in-flight producers. The writeback source retires them.
module bypass_scoreboard #(
    parameter int NREGS = 32,
    parameter int DW    = 32,
    parameter int NSRC  = 8,
    parameter int NRD   = 2,
    localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NSRC-1:0]      src_wr_en_i,
    input  logic [NSRC-1:0]      src_valid_i,
    input  logic [NSRC*AW-1:0]   src_addr_i,
    input  logic [NSRC*DW-1:0]   src_data_i,
    input  logic [NRD-1:0]       rd_en_i,
    input  logic [NRD*AW-1:0]    rd_addr_i,
    input  logic                 issue_i,
    input  logic [AW-1:0]        issue_addr_i,
    input  logic                 flush_i,
    output logic [NRD-1:0]       bypass_en_o,
    output logic [NRD*DW-1:0]    bypass_data_o,
    output logic                 stall_o,
    output logic [NREGS-1:0]     busy_o,
    output logic [31:0]          stall_cnt_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [31:0]      stallCnt_q;
    logic [NRD-1:0]   portHazard;
    logic [AW-1:0]    rdAddr;
    logic [AW-1:0]    wbAddr;
    logic             winHit;
    logic             winValid;
    logic [DW-1:0]    winData;

    assign wbAddr = src_addr_i[(NSRC-1)*AW +: AW];

    // Per read port: find the youngest matching source, then forward it or raise a hazard.
    // Sources are scanned from oldest to youngest so the lowest index overwrites the others.
    // Every output here is held at zero while reset is asserted.
    always_comb begin
        bypass_en_o   = '0;
        bypass_data_o = '0;
        portHazard    = '0;
        rdAddr        = '0;
        winHit        = 1'b0;
        winValid      = 1'b0;
        winData       = '0;
        for (int r = 0; r < NRD; r++) begin
            rdAddr   = rd_addr_i[r*AW +: AW];
            winHit   = 1'b0;
            winValid = 1'b0;
            winData  = '0;
            for (int i = NSRC-1; i >= 0; i--) begin
                if (src_wr_en_i[i] && (src_addr_i[i*AW +: AW] == rdAddr) && (rdAddr != '0)) begin
                    winHit   = 1'b1;
                    winValid = src_valid_i[i];
                    winData  = src_data_i[i*DW +: DW];
                end
            end
            if (!rst_i && rd_en_i[r] && winHit && winValid) begin
                bypass_en_o[r]            = 1'b1;
                bypass_data_o[r*DW +: DW] = winData;
            end
            if (!rst_i && rd_en_i[r] && (rdAddr != '0) &&
                ((winHit && !winValid) || (!winHit && busy_q[rdAddr]))) begin
                portHazard[r] = 1'b1;
            end
        end
    end

    assign stall_o = |portHazard;

    // Next scoreboard state. A writeback retire clears its register. An accepted issue
    // then sets its register, so a younger producer wins over a same-cycle retire.
    always_comb begin
        busy_d = busy_q;
        if (src_wr_en_i[NSRC-1] && src_valid_i[NSRC-1]) begin
            busy_d[wbAddr] = 1'b0;
        end
        if (issue_i && !stall_o && (issue_addr_i != '0)) begin
            busy_d[issue_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Busy register. A flush drops all in-flight tracking, just as reset does.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Saturating stall-cycle counter. Only reset clears it, so it survives flushes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stallCnt_q <= '0;
        end else if (stall_o && (stallCnt_q != 32'hFFFF_FFFF)) begin
            stallCnt_q <= stallCnt_q + 32'd1;
        end
    end

    assign busy_o      = busy_q;
    assign stall_cnt_o = stallCnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// tb_bypass_scoreboard: directed vectors for bypass_scoreboard with a queue-based scoreboard.
// Each vector drives the inputs for one cycle and queues its hand-computed expected outputs.
// A monitor pops the queue on the falling edge and compares against the DUT.
module tb_bypass_scoreboard;

    localparam int NREGS = 32;
    localparam int DW    = 32;
    localparam int NSRC  = 8;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    typedef struct {
        logic [NSRC-1:0]          wrEn;
        logic [NSRC-1:0]          valid;
        logic [NSRC-1:0][AW-1:0]  addr;
        logic [NSRC-1:0][DW-1:0]  data;
        logic [NRD-1:0]           rdEn;
        logic [NRD-1:0][AW-1:0]   rdAddr;
        logic                     issue;
        logic [AW-1:0]            issueAddr;
        logic                     flush;
        logic                     rst;
    } vec_t;

    typedef struct {
        string                    name;
        logic [NRD-1:0]           bypEn;
        logic [NRD-1:0][DW-1:0]   bypData;
        logic                     stall;
        logic [NREGS-1:0]         busy;
        logic [31:0]              stallCnt;
    } exp_t;

    logic                clk;
    logic                rst_i;
    logic [NSRC-1:0]     src_wr_en_i;
    logic [NSRC-1:0]     src_valid_i;
    logic [NSRC*AW-1:0]  src_addr_i;
    logic [NSRC*DW-1:0]  src_data_i;
    logic [NRD-1:0]      rd_en_i;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic                issue_i;
    logic [AW-1:0]       issue_addr_i;
    logic                flush_i;
    logic [NRD-1:0]      bypass_en_o;
    logic [NRD*DW-1:0]   bypass_data_o;
    logic                stall_o;
    logic [NREGS-1:0]    busy_o;
    logic [31:0]         stall_cnt_o;

    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    vec_t v;
    exp_t e;

    bypass_scoreboard #(
        .NREGS (NREGS),
        .DW    (DW),
        .NSRC  (NSRC),
        .NRD   (NRD)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .src_wr_en_i   (src_wr_en_i),
        .src_valid_i   (src_valid_i),
        .src_addr_i    (src_addr_i),
        .src_data_i    (src_data_i),
        .rd_en_i       (rd_en_i),
        .rd_addr_i     (rd_addr_i),
        .issue_i       (issue_i),
        .issue_addr_i  (issue_addr_i),
        .flush_i       (flush_i),
        .bypass_en_o   (bypass_en_o),
        .bypass_data_o (bypass_data_o),
        .stall_o       (stall_o),
        .busy_o        (busy_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the vector list completed");
        $fatal(1, "[TB] watchdog");
    end

    // Clear the working vector and its expectations for a new step.
    task automatic startVec(input string name);
        v.wrEn = '0; v.valid = '0; v.addr = '0; v.data = '0;
        v.rdEn = '0; v.rdAddr = '0; v.issue = 1'b0; v.issueAddr = '0;
        v.flush = 1'b0; v.rst = 1'b0;
        e.name = name; e.bypEn = '0; e.bypData = '0; e.stall = 1'b0;
        e.busy = '0; e.stallCnt = '0;
    endtask

    // Drive one vector just after the rising edge and queue what it should produce.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        rst_i        = v.rst;
        src_wr_en_i  = v.wrEn;
        src_valid_i  = v.valid;
        src_addr_i   = v.addr;
        src_data_i   = v.data;
        rd_en_i      = v.rdEn;
        rd_addr_i    = v.rdAddr;
        issue_i      = v.issue;
        issue_addr_i = v.issueAddr;
        flush_i      = v.flush;
        expQ.push_back(e);
    endtask

    // One field compare. Any mismatch prints a FAIL line.
    task automatic checkOutput(input string name, input string field,
                               input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Monitor: on each falling edge, pop one pending expectation and compare it.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                x = expQ.pop_front();
                checkOutput(x.name, "bypass_en",  64'(bypass_en_o),   64'(x.bypEn));
                checkOutput(x.name, "bypass_data", 64'(bypass_data_o), 64'(x.bypData));
                checkOutput(x.name, "stall",      64'(stall_o),       64'(x.stall));
                checkOutput(x.name, "busy",       64'(busy_o),        64'(x.busy));
                checkOutput(x.name, "stall_cnt",  64'(stall_cnt_o),   64'(x.stallCnt));
            end
        end
    end

    // Directed vector list.
    initial begin
        int waitCycles;
        rst_i = 1'b1; src_wr_en_i = '0; src_valid_i = '0; src_addr_i = '0; src_data_i = '0;
        rd_en_i = '0; rd_addr_i = '0; issue_i = 1'b0; issue_addr_i = '0; flush_i = 1'b0;

        startVec("reset");
        v.rst = 1'b1; v.wrEn[0] = 1'b1; v.valid[0] = 1'b1; v.addr[0] = 5; v.data[0] = 32'h1234;
        v.rdEn = 2'b11; v.rdAddr[0] = 5; v.rdAddr[1] = 5;
        applyStimulus();

        startVec("resetIssue");
        v.rst = 1'b1; v.wrEn[0] = 1'b1; v.valid[0] = 1'b1; v.addr[0] = 5; v.data[0] = 32'h1234;
        v.rdEn = 2'b11; v.rdAddr[0] = 5; v.rdAddr[1] = 5; v.issue = 1'b1; v.issueAddr = 5;
        applyStimulus();

        startVec("postReset");
        applyStimulus();

        startVec("priority");
        v.wrEn[0] = 1'b1; v.valid[0] = 1'b1; v.addr[0] = 5; v.data[0] = 32'hAAAA_0000;
        v.wrEn[3] = 1'b1; v.valid[3] = 1'b1; v.addr[3] = 5; v.data[3] = 32'h5555;
        v.rdEn = 2'b01; v.rdAddr[0] = 5;
        e.bypEn = 2'b01; e.bypData[0] = 32'hAAAA_0000;
        applyStimulus();

        startVec("youngInvalid");
        v.wrEn[0] = 1'b1; v.valid[0] = 1'b0; v.addr[0] = 5; v.data[0] = 32'hAAAA_0000;
        v.wrEn[3] = 1'b1; v.valid[3] = 1'b1; v.addr[3] = 5; v.data[3] = 32'h5555;
        v.rdEn = 2'b10; v.rdAddr[1] = 5; v.issue = 1'b1; v.issueAddr = 6;
        e.stall = 1'b1;
        applyStimulus();

        startVec("bothPorts");
        v.wrEn[3] = 1'b1; v.valid[3] = 1'b1; v.addr[3] = 5; v.data[3] = 32'h5555;
        v.rdEn = 2'b11; v.rdAddr[0] = 5; v.rdAddr[1] = 5;
        e.bypEn = 2'b11; e.bypData[0] = 32'h5555; e.bypData[1] = 32'h5555; e.stallCnt = 1;
        applyStimulus();

        startVec("issue7");
        v.issue = 1'b1; v.issueAddr = 7;
        e.stallCnt = 1;
        applyStimulus();

        for (int k = 0; k < 3; k++) begin
            startVec($sformatf("miss%0d", k));
            v.wrEn[4] = 1'b1; v.valid[4] = 1'b0; v.addr[4] = 7; v.data[4] = 32'h77;
            v.rdEn = 2'b10; v.rdAddr[1] = 7;
            e.stall = 1'b1; e.busy = 32'h80; e.stallCnt = 32'(1 + k);
            applyStimulus();
        end

        startVec("missDone");
        v.wrEn[4] = 1'b1; v.valid[4] = 1'b1; v.addr[4] = 7; v.data[4] = 32'h77;
        v.rdEn = 2'b10; v.rdAddr[1] = 7;
        e.bypEn = 2'b10; e.bypData[1] = 32'h77; e.busy = 32'h80; e.stallCnt = 4;
        applyStimulus();

        startVec("issue9retire7");
        v.issue = 1'b1; v.issueAddr = 9;
        v.wrEn[7] = 1'b1; v.valid[7] = 1'b1; v.addr[7] = 7; v.data[7] = 32'h7;
        e.busy = 32'h80; e.stallCnt = 4;
        applyStimulus();

        for (int k = 0; k < 2; k++) begin
            startVec($sformatf("sbStall%0d", k));
            v.rdEn = 2'b01; v.rdAddr[0] = 9;
            e.stall = 1'b1; e.busy = 32'h200; e.stallCnt = 32'(4 + k);
            applyStimulus();
        end

        startVec("wbForward");
        v.wrEn[7] = 1'b1; v.valid[7] = 1'b1; v.addr[7] = 9; v.data[7] = 32'h99;
        v.rdEn = 2'b01; v.rdAddr[0] = 9;
        e.bypEn = 2'b01; e.bypData[0] = 32'h99; e.busy = 32'h200; e.stallCnt = 6;
        applyStimulus();

        startVec("retired9");
        v.rdEn = 2'b01; v.rdAddr[0] = 9;
        e.stallCnt = 6;
        applyStimulus();

        startVec("issue12");
        v.issue = 1'b1; v.issueAddr = 12;
        e.stallCnt = 6;
        applyStimulus();

        startVec("setClear12");
        v.issue = 1'b1; v.issueAddr = 12;
        v.wrEn[7] = 1'b1; v.valid[7] = 1'b1; v.addr[7] = 12; v.data[7] = 32'hC;
        e.busy = 32'h1000; e.stallCnt = 6;
        applyStimulus();

        startVec("setWins");
        e.busy = 32'h1000; e.stallCnt = 6;
        applyStimulus();

        startVec("issue3");
        v.issue = 1'b1; v.issueAddr = 3;
        e.busy = 32'h1000; e.stallCnt = 6;
        applyStimulus();

        startVec("issue4");
        v.issue = 1'b1; v.issueAddr = 4;
        e.busy = 32'h1008; e.stallCnt = 6;
        applyStimulus();

        startVec("flush");
        v.flush = 1'b1;
        e.busy = 32'h1018; e.stallCnt = 6;
        applyStimulus();

        startVec("postFlush");
        e.stallCnt = 6;
        applyStimulus();

        startVec("x0");
        v.issue = 1'b1; v.issueAddr = 0;
        v.wrEn[0] = 1'b1; v.valid[0] = 1'b1; v.addr[0] = 0; v.data[0] = 32'hDEAD;
        v.rdEn = 2'b11;
        e.stallCnt = 6;
        applyStimulus();

        startVec("x0after");
        v.rdEn = 2'b11;
        e.stallCnt = 6;
        applyStimulus();

        startVec("issue8");
        v.issue = 1'b1; v.issueAddr = 8;
        e.stallCnt = 6;
        applyStimulus();

        startVec("midReset");
        v.rst = 1'b1; v.rdEn = 2'b11; v.rdAddr[0] = 8; v.rdAddr[1] = 8;
        v.wrEn[1] = 1'b1; v.valid[1] = 1'b0; v.addr[1] = 8;
        e.busy = 32'h100; e.stallCnt = 6;
        applyStimulus();

        startVec("afterMidReset");
        v.rdEn = 2'b01; v.rdAddr[0] = 8;
        applyStimulus();

        startVec("retireNonBusy");
        v.wrEn[7] = 1'b1; v.valid[7] = 1'b1; v.addr[7] = 8; v.data[7] = 32'h88;
        v.rdEn = 2'b01; v.rdAddr[0] = 8;
        e.bypEn = 2'b01; e.bypData[0] = 32'h88;
        applyStimulus();

        startVec("final");
        applyStimulus();

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
Parametrised operand-forwarding and hazard controller for the in-order integer pipeline. It generalises the fixed exe/mult1-5/cache/write forwarding set to NSRC prioritised bypass sources and NRD read ports. It adds a registered per-register busy scoreboard, so stalls come from tracked in-flight producers rather than from address matching alone. It sits beside the decode/register-file stage, feeding operand muxes and the core stall line.

Parameters:
NREGS, 32, architectural registers; AW = clog2(NREGS); register 0 hard-wired zero
DW, 32, data width
NSRC, 8, bypass sources; index 0 youngest (exe), NSRC-1 oldest (writeback)
NRD, 2, operand read ports

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-high
src_wr_en_i  in  NSRC  source i will write its destination
src_valid_i  in  NSRC  source i data is final (0 = e.g. TLB/cache miss, mult not done)
src_addr_i  in  NSRC*AW  destination of source i, slice i
src_data_i  in  NSRC*DW  data of source i, slice i
rd_en_i  in  NRD  read port r uses its operand
rd_addr_i  in  NRD*AW  operand address per port
issue_i  in  1  decode issues an instruction writing a register
issue_addr_i  in  AW  destination of the issued instruction
flush_i  in  1  pipeline flush
bypass_en_o  out  NRD  port r takes bypass data instead of register file
bypass_data_o  out  NRD*DW  forwarded data per port
stall_o  out  1  hold decode/issue
busy_o  out  NREGS  scoreboard state, bit 0 always 0
stall_cnt_o  out  32  saturating count of stalled cycles

Behaviour:
- Forwarding is combinational from the current inputs plus registered busy bits. Latency is 0 cycles.
- Port r match set: src i with src_wr_en_i[i] && src_addr_i[i]==rd_addr_i[r] && rd_addr_i[r]!=0.
- Priority: lowest matching index wins, and only that source is considered.
- bypass_en_o[r]=1 iff rd_en_i[r] && winner exists && src_valid_i[winner]. Then bypass_data_o[r]=src_data_i[winner]; otherwise bypass_data_o[r]=0.
- Hazard on port r: rd_en_i[r] && rd_addr_i[r]!=0 && ((winner exists && !src_valid_i[winner]) || (no winner && busy[rd_addr_i[r]])).
- stall_o = OR of port hazards, forced 0 while rst_i=1.
- Scoreboard update, next edge, in priority order:
  - rst_i or flush_i: all busy cleared.
  - Clear: busy[a] cleared when src_wr_en_i[NSRC-1] && src_valid_i[NSRC-1] && src_addr_i[NSRC-1]==a. This is the writeback retire.
  - Set: if issue_i && !stall_o && issue_addr_i!=0, busy[issue_addr_i] set. Set wins over a clear of the same register in the same cycle (new producer is younger).
  - issue_i while stall_o=1 has no effect; decode re-presents it.
  - Issue to register 0 is ignored. busy[0] is constant 0.
- stall_cnt_o: +1 each cycle stall_o=1; saturates at 0xFFFFFFFF; cleared by reset only, not by flush.
- Reset values: busy_o=0, stall_cnt_o=0. Combinational outputs are gated during reset: bypass_en_o=0, bypass_data_o=0, stall_o=0.
- Reset mid-operation discards all in-flight tracking; any later retire for a non-busy register is harmless (clear of 0).
- Both ports reading the same register resolve independently and identically.
- NSRC=1 degenerates to a writeback-only scoreboard. Widths follow from parameters with no truncation.

Test Plan:
- Reset: rst_i=1 with matching exe source active -> bypass_en_o=00, stall_o=0; after release busy_o=0, stall_cnt_o=0.
- Priority: src0 (addr 5, data 0xAAAA0000, valid) and src3 (addr 5, data 0x5555) both active, rd_addr port0=5 -> bypass_en_o[0]=1, data 0xAAAA0000, stall_o=0.
- Miss stall: issue addr 7, then src4 addr 7 wr_en valid=0 while port1 reads 7 -> stall_o=1 each cycle and stall_cnt_o increments by 1 per cycle. When valid=1 arrives -> forward, stall_o=0.
- Scoreboard stall: issue addr 9, no matching source active, port0 reads 9 -> stall_o=1. Writeback (src NSRC-1) addr 9 valid -> forwarded same cycle; busy_o[9]=0 next cycle.
- Simultaneous set/clear: writeback retires addr 12 while issue_i addr 12 in the same cycle -> busy_o[12]=1 next cycle.
- Flush and x0: busy on regs 3,4; flush_i=1 -> busy_o=0 next cycle. Issue addr 0 and read addr 0 with src0 addr 0 active -> no bypass, no stall, busy_o[0]=0.
